// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU: FETCH -> EXEC -> (MEM) with req/ack memory handshakes.
// Detects a jump-to-self as halt and keeps a saturating retired-instruction count.
module hack_cpu_mc #(
  parameter int DW = 16,
  parameter int AW = 15,
  parameter int CW = 32
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [DW-1:0] inst_i,
  output logic          imem_req_o,
  input  logic          imem_ack_i,
  output logic [AW-1:0] pc_o,
  output logic          dmem_req_o,
  input  logic          dmem_ack_i,
  output logic          dmem_wr_en_o,
  output logic [AW-1:0] dmem_addr_o,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] data_o,
  output logic          halt_o,
  output logic [CW-1:0] retired_o
);

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] pc_reg, pc_next;
  logic [DW-1:0] a_reg, a_next;
  logic [DW-1:0] d_reg, d_next;
  logic [DW-1:0] ir_reg, ir_next;
  logic [CW-1:0] retired_reg, retired_next;
  logic          halt_reg, halt_next;

  logic          is_c, a_bit, zx, nx, zy, ny, f_add, no;
  logic [2:0]    dest, jmp;
  logic [DW-1:0] x0, x1, y0, y1, f_out, alu;
  logic          ng, zr, taken, halt_hit, complete, retire;
  logic [AW-1:0] pc_inc, pc_target;

  assign is_c  = ir_reg[DW-1];
  assign a_bit = ir_reg[12];
  assign {zx, nx, zy, ny, f_add, no} = ir_reg[11:6];
  assign dest  = ir_reg[5:3];
  assign jmp   = ir_reg[2:0];

  // y reads memory directly from data_i so a read-modify-write finishes in one handshake
  assign y0    = zy ? '0 : (a_bit ? data_i : a_reg);
  assign y1    = ny ? ~y0 : y0;
  assign x0    = zx ? '0 : d_reg;
  assign x1    = nx ? ~x0 : x0;
  assign f_out = f_add ? (x1 + y1) : (x1 & y1);
  assign alu   = no ? ~f_out : f_out;

  assign ng        = alu[DW-1];
  assign zr        = (alu == '0);
  assign taken     = (jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr);
  assign pc_inc    = pc_reg + 1'b1;
  assign pc_target = taken ? a_reg[AW-1:0] : pc_inc;
  assign halt_hit  = (jmp == 3'b111) && (a_reg[AW-1:0] == pc_reg);

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    a_next       = a_reg;
    d_next       = d_reg;
    ir_next      = ir_reg;
    halt_next    = halt_reg;
    retired_next = retired_reg;
    complete     = 1'b0;
    retire       = 1'b0;

    case (state_reg)
      FETCH: begin
        if (imem_ack_i) begin
          ir_next    = inst_i;
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (!is_c) begin
          a_next     = {1'b0, ir_reg[DW-2:0]};
          pc_next    = pc_inc;
          retire     = 1'b1;
          state_next = FETCH;
        end else if (a_bit || dest[0]) begin
          state_next = MEM;
        end else begin
          complete = 1'b1;
        end
      end
      MEM: begin
        if (dmem_ack_i) complete = 1'b1;
      end
      default: state_next = HALT;
    endcase

    // Jump target and M address both use A as it stood before this instruction
    if (complete) begin
      if (dest[2]) a_next = alu;
      if (dest[1]) d_next = alu;
      pc_next    = pc_target;
      retire     = 1'b1;
      halt_next  = halt_hit;
      state_next = halt_hit ? HALT : FETCH;
    end

    if (retire && (retired_reg != '1)) retired_next = retired_reg + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg   <= FETCH;
      pc_reg      <= '0;
      a_reg       <= '0;
      d_reg       <= '0;
      ir_reg      <= '0;
      retired_reg <= '0;
      halt_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      a_reg       <= a_next;
      d_reg       <= d_next;
      ir_reg      <= ir_next;
      retired_reg <= retired_next;
      halt_reg    <= halt_next;
    end
  end

  assign imem_req_o   = (state_reg == FETCH);
  assign dmem_req_o   = (state_reg == MEM);
  assign dmem_wr_en_o = (state_reg == MEM) && dest[0];
  assign dmem_addr_o  = a_reg[AW-1:0];
  assign data_o       = alu;
  assign pc_o         = pc_reg;
  assign halt_o       = halt_reg;
  assign retired_o    = retired_reg;

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Bench for hack_cpu_mc: instruction-level Hack model checked on every fetch and
// data access, plus directed programs with hand-computed final states.
module tb_hack_cpu_mc;

  logic        clk;
  logic        reset_i, imem_req_o, imem_ack_i, dmem_req_o, dmem_ack_i, dmem_wr_en_o, halt_o;
  logic [15:0] inst_i, data_i, data_o;
  logic [14:0] pc_o, dmem_addr_o;
  logic [31:0] retired_o;

  logic        reset_w, imem_req_w, imem_ack_w, dmem_req_w, dmem_ack_w, dmem_wr_w, halt_w;
  logic [23:0] inst_w, data_iw, data_ow;
  logic [19:0] pc_w, addr_w;
  logic [31:0] retired_w;

  logic [15:0] imem [32];
  logic [15:0] ram_init [32];
  logic [15:0] ram [32];
  logic [15:0] mdl_mem [32];

  logic [15:0] m_a, m_d;
  logic [14:0] m_pc;
  int          m_ret;
  logic        cur_mem, cur_wr;
  logic [14:0] cur_addr, cur_pc;
  logic [15:0] cur_wdata;
  int          dlen, last_dlen;

  int          dwait, dcnt;
  logic        force_ack, dack_spur;
  int          n_checks, n_fail;

  hack_cpu_mc dut (
    .clk_i(clk), .reset_i(reset_i), .inst_i(inst_i),
    .imem_req_o(imem_req_o), .imem_ack_i(imem_ack_i), .pc_o(pc_o),
    .dmem_req_o(dmem_req_o), .dmem_ack_i(dmem_ack_i), .dmem_wr_en_o(dmem_wr_en_o),
    .dmem_addr_o(dmem_addr_o), .data_i(data_i), .data_o(data_o),
    .halt_o(halt_o), .retired_o(retired_o)
  );

  hack_cpu_mc #(.DW(24), .AW(20), .CW(32)) dut_w (
    .clk_i(clk), .reset_i(reset_w), .inst_i(inst_w),
    .imem_req_o(imem_req_w), .imem_ack_i(imem_ack_w), .pc_o(pc_w),
    .dmem_req_o(dmem_req_w), .dmem_ack_i(dmem_ack_w), .dmem_wr_en_o(dmem_wr_w),
    .dmem_addr_o(addr_w), .data_i(data_iw), .data_o(data_ow),
    .halt_o(halt_w), .retired_o(retired_w)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] prog24(input logic [19:0] p);
    case (p)
      20'd0:       return 24'h7FFFFF;  // @0x7FFFFF
      20'd1:       return 24'h800308;  // M=D
      20'd2:       return 24'h0FFFFF;  // @0xFFFFF
      20'd3:       return 24'h800A87;  // 0;JMP
      20'hFFFFF:   return 24'h000005;  // @5
      default:     return 24'h800A87;
    endcase
  endfunction

  // Memory responders: drive inputs 2 time units after each rising edge
  always @(posedge clk) begin
    if (reset_i) begin
      for (int i = 0; i < 32; i++) ram[i] = ram_init[i];
    end else if (dmem_req_o && dmem_ack_i && dmem_wr_en_o) begin
      ram[dmem_addr_o[4:0]] = data_o;
    end
    #2;
    imem_ack_i = 1'b1;
    inst_i     = imem[pc_o[4:0]];
    if (dmem_req_o === 1'b1) begin
      dmem_ack_i = (dcnt == dwait) || force_ack;
      dcnt++;
    end else begin
      dmem_ack_i = dack_spur;
      dcnt = 0;
    end
    data_i     = ram[dmem_addr_o[4:0]];
    imem_ack_w = 1'b1;
    inst_w     = prog24(pc_w);
    dmem_ack_w = dmem_req_w;
    data_iw    = '0;
  end

  // Architectural model: executes one whole instruction per accepted fetch
  task automatic step_model(input logic [15:0] ins);
    logic [15:0] x, y, r;
    logic taken;
    if (!ins[15]) begin
      m_a     = {1'b0, ins[14:0]};
      m_pc    = m_pc + 15'd1;
      cur_mem = 1'b0;
    end else begin
      x = m_d;
      y = ins[12] ? mdl_mem[m_a[4:0]] : m_a;
      if (ins[11]) x = 16'd0;
      if (ins[10]) x = ~x;
      if (ins[9])  y = 16'd0;
      if (ins[8])  y = ~y;
      r = ins[7] ? x + y : x & y;
      if (ins[6]) r = ~r;
      cur_mem   = ins[12] | ins[3];
      cur_addr  = m_a[14:0];
      cur_wr    = ins[3];
      cur_wdata = r;
      cur_pc    = m_pc;
      if (ins[3]) mdl_mem[m_a[4:0]] = r;
      taken = (ins[2] && $signed(r) < 0) || (ins[1] && r == 16'd0) || (ins[0] && $signed(r) > 0);
      m_pc = taken ? m_a[14:0] : m_pc + 15'd1;
      if (ins[4]) m_d = r;
      if (ins[5]) m_a = r;
    end
    m_ret++;
  endtask

  always @(negedge clk) begin
    if (reset_i) begin
      m_pc = '0; m_a = '0; m_d = '0; m_ret = 0; cur_mem = 1'b0; dlen = 0;
      for (int i = 0; i < 32; i++) mdl_mem[i] = ram_init[i];
    end else begin
      check("req_exclusive", imem_req_o & dmem_req_o, 0);
      if (imem_req_o && imem_ack_i) begin
        check("fetch_pc", pc_o, m_pc);
        check("fetch_retired", retired_o, m_ret);
        check("fetch_a", dut.a_reg, m_a);
        check("fetch_d", dut.d_reg, m_d);
        step_model(imem[m_pc[4:0]]);
      end
      if (dmem_req_o) begin
        check("dmem_expected", cur_mem, 1);
        check("dmem_addr", dmem_addr_o, cur_addr);
        check("dmem_wr_en", dmem_wr_en_o, cur_wr);
        check("dmem_pc_hold", pc_o, cur_pc);
        if (dmem_ack_i && cur_wr) check("dmem_wdata", data_o, cur_wdata);
        dlen++;
        if (dmem_ack_i) begin
          last_dlen = dlen;
          dlen = 0;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 reset_i = 1'b1;
    @(posedge clk); #1 reset_i = 1'b0;
    @(negedge clk);
    check("rst_imem_req", imem_req_o, 1);
    check("rst_dmem_req", dmem_req_o, 0);
    check("rst_pc", pc_o, 0);
    check("rst_retired", retired_o, 0);
    check("rst_halt", halt_o, 0);
    check("rst_a", dut.a_reg, 0);
    check("rst_d", dut.d_reg, 0);
  endtask

  task automatic wait_halt();
    int k = 0;
    while (halt_o !== 1'b1 && k < 600) begin
      @(negedge clk);
      k++;
    end
    check("halt_reached", halt_o, 1);
    check("halt_pc_model", pc_o, m_pc);
    check("halt_ret_model", retired_o, m_ret);
    check("halt_d_model", dut.d_reg, m_d);
    check("halt_a_model", dut.a_reg, m_a);
    @(negedge clk);
    for (int i = 0; i < 32; i++) if (ram[i] !== mdl_mem[i]) check("ram_model", ram[i], mdl_mem[i]);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 32; i++) begin
      imem[i] = 16'hEA87;
      ram_init[i] = 16'h0000;
    end
  endtask

  initial begin
    int k;
    logic [31:0] frozen;
    n_checks = 0; n_fail = 0; dlen = 0; last_dlen = 0;
    reset_i = 1'b1; reset_w = 1'b1;
    dwait = 0; force_ack = 1'b0; dack_spur = 1'b0;
    clear_prog();

    // 24-bit instance: wide A-instruction, wide address, PC wrap
    repeat (2) @(posedge clk);
    #1 reset_w = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (dmem_req_w !== 1'b1 && k < 50);
    check("w_dmem_req", dmem_req_w, 1);
    check("w_dmem_addr", addr_w, 20'hFFFFF);
    check("w_a_reg", dut_w.a_reg, 24'h7FFFFF);
    check("w_wr_en", dmem_wr_w, 1);
    check("w_wdata", data_ow, 0);
    k = 0;
    while (pc_w !== 20'hFFFFF && k < 50) begin @(negedge clk); k++; end
    check("w_pc_top", pc_w, 20'hFFFFF);
    check("w_ret_top", retired_w, 4);
    k = 0;
    while (pc_w === 20'hFFFFF && k < 50) begin @(negedge clk); k++; end
    check("w_pc_wrap", pc_w, 0);
    check("w_ret_wrap", retired_w, 5);
    reset_w = 1'b1;

    // @2; D=A; @3; 0;JMP -- halts at PC 3, spurious dmem acks present
    clear_prog();
    imem[0] = 16'h0002; imem[1] = 16'hEC10; imem[2] = 16'h0003; imem[3] = 16'hEA87;
    dack_spur = 1'b1;
    do_reset();
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("p1_d_after4", dut.d_reg, 2);
    check("p1_pc_after4", pc_o, 2);
    check("p1_ret_after4", retired_o, 2);
    wait_halt();
    check("p1_halt_pc", pc_o, 3);
    check("p1_halt_ret", retired_o, 4);
    frozen = retired_o;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("p1_no_imem_req", imem_req_o, 0);
      check("p1_no_dmem_req", dmem_req_o, 0);
      check("p1_ret_frozen", retired_o, frozen);
    end
    dack_spur = 1'b0;
    do_reset();

    // @9; D=A; @5; M=D+1 with 3 wait cycles; @5; 0;JMP
    clear_prog();
    imem[0] = 16'h0009; imem[1] = 16'hEC10; imem[2] = 16'h0005; imem[3] = 16'hE7C8;
    imem[4] = 16'h0005; imem[5] = 16'hEA87;
    dwait = 3;
    do_reset();
    wait_halt();
    check("p2_req_cycles", last_dlen, 4);
    check("p2_ram5", ram[5], 10);
    check("p2_halt_pc", pc_o, 5);
    check("p2_halt_ret", retired_o, 6);

    // Same program, reset while waiting in MEM with an ack on the reset edge
    dwait = 50;
    do_reset();
    k = 0;
    while (dmem_req_o !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    check("p5_in_mem", dmem_req_o, 1);
    @(posedge clk); #1 reset_i = 1'b1; force_ack = 1'b1;
    @(posedge clk); #1 reset_i = 1'b0; force_ack = 1'b0; dwait = 0;
    @(negedge clk);
    check("p5_dmem_dropped", dmem_req_o, 0);
    check("p5_imem_req", imem_req_o, 1);
    check("p5_pc", pc_o, 0);
    check("p5_ret", retired_o, 0);
    check("p5_d", dut.d_reg, 0);
    check("p5_ram_untouched", ram[5], 0);
    wait_halt();
    check("p5_ram5_rerun", ram[5], 10);

    // @7; M=M+1 (0xFFFF -> 0); D=M; D;JEQ -> 7; 0;JMP halts at 7
    clear_prog();
    ram_init[7] = 16'hFFFF;
    imem[0] = 16'h0007; imem[1] = 16'hFDC8; imem[2] = 16'hFC10; imem[3] = 16'hE302;
    imem[7] = 16'hEA87;
    dwait = 1;
    do_reset();
    wait_halt();
    check("p3_ram7", ram[7], 0);
    check("p3_halt_pc", pc_o, 7);
    check("p3_d", dut.d_reg, 0);
    check("p3_ret", retired_o, 5);

    // D=-1; @20; D;JLT -> 20 (halt); then D=1 falls through to 3, halts at 4
    clear_prog();
    imem[0] = 16'hEE90; imem[1] = 16'h0014; imem[2] = 16'hE304; imem[3] = 16'h0004;
    imem[4] = 16'hEA87; imem[20] = 16'hEA87;
    dwait = 0;
    do_reset();
    wait_halt();
    check("p4_jlt_pc", pc_o, 20);
    check("p4_jlt_ret", retired_o, 4);
    check("p4_jlt_d", dut.d_reg, 16'hFFFF);
    imem[0] = 16'hEFD0;
    do_reset();
    wait_halt();
    check("p4_nojmp_pc", pc_o, 4);
    check("p4_nojmp_ret", retired_o, 5);
    check("p4_nojmp_d", dut.d_reg, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hack_cpu_mc.md
HACK_CPU_MC -- requirements
Module: hack_cpu_mc

Interface
REQ-001 The block SHALL have parameter DW, default 16, meaning data/instruction width; legal values are DW >= 16.
REQ-002 The block SHALL have parameter AW, default 15, meaning address width of pc_o and dmem_addr_o; legal values are AW <= DW-1.
REQ-003 The block SHALL have parameter CW, default 32, meaning width of the retired-instruction counter.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_i, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port inst_i, input, DW bits: instruction word, valid when imem_ack_i=1.
REQ-007 The block SHALL have port imem_req_o / imem_ack_i, output/input, 1 bit each: instruction fetch handshake.
REQ-008 The block SHALL have port pc_o, output, AW bits: fetch address.
REQ-009 The block SHALL have port dmem_req_o / dmem_ack_i, output/input, 1 bit each: data-memory handshake.
REQ-010 The block SHALL have port dmem_wr_en_o, output, 1 bit: write qualifier, valid only while dmem_req_o=1.
REQ-011 The block SHALL have port dmem_addr_o, output, AW bits: A[AW-1:0].
REQ-012 The block SHALL have port data_i, input, DW bits: read data, valid when dmem_ack_i=1.
REQ-013 The block SHALL have port data_o, output, DW bits: ALU result, which is the write data.
REQ-014 The block SHALL have port halt_o, output, 1 bit: self-loop detected.
REQ-015 The block SHALL have port retired_o, output, CW bits: count of completed instructions.

Function
REQ-016 The state machine SHALL have states FETCH, EXEC, MEM and HALT.
REQ-017 In FETCH, imem_req_o SHALL be 1; when imem_ack_i=1 the block SHALL latch inst_i into IR and go to EXEC; it SHALL wait indefinitely otherwise.
REQ-018 Decode in EXEC: IR[DW-1]=0 is an A-instruction; on it the block SHALL load A with zero-extended IR[DW-2:0], set PC=PC+1, and go to FETCH.
REQ-019 Decode in EXEC: IR[DW-1]=1 is a C-instruction; IR[DW-2:13] SHALL be ignored.
REQ-020 C-instruction fields SHALL be: a=IR[12], zx..no=IR[11:6], d1..d3=IR[5:3] (A, D, M), j1..j3=IR[2:0] (lt, eq, gt).
REQ-021 The ALU SHALL take x=D and y=(a ? M : A), with Hack semantics: zero, negate, AND/ADD, negate output; arithmetic is modulo 2^DW.
REQ-022 A C-instruction with a=0 and d3=0 SHALL complete in EXEC: write A/D per d1/d2, update PC, increment retired_o, then go to FETCH (2 cycles minimum per instruction).
REQ-023 A C-instruction with a=1 or d3=1 SHALL go to MEM.
REQ-024 In MEM, dmem_req_o=1, dmem_addr_o=A and dmem_wr_en_o=d3 SHALL be held stable until dmem_ack_i=1.
REQ-025 On the MEM ack cycle, the ALU SHALL use data_i as M; memory samples data_o in the same cycle (read-modify-write, e.g. M=M+1, works in one handshake); the block SHALL write A/D, update PC, increment retired_o, and go to FETCH.
REQ-026 A and D writes SHALL use the A value from before the instruction for addressing; a d1 write takes effect at the completing edge.
REQ-027 The jump condition SHALL be (j1&ng)|(j2&zr)|(j3&~ng&~zr), where ng=result[DW-1] and zr=(result==0).
REQ-028 On a taken jump, PC SHALL become A_old[AW-1:0]; otherwise PC SHALL become PC+1, wrapping from 2^AW-1 to 0.
REQ-029 Halt: on a C-instruction with j=111 and A_old[AW-1:0]==PC, the instruction SHALL retire, halt_o SHALL become 1 and the state SHALL go to HALT; HALT SHALL issue no requests and be left only by reset.
REQ-030 retired_o SHALL saturate at 2^CW-1, with no wrap.
REQ-031 imem_req_o and dmem_req_o SHALL never be 1 in the same cycle.
REQ-032 An ack arriving without the matching req SHALL be ignored.

Reset
REQ-033 When reset_i=1 at a clock edge, the block SHALL set state=FETCH, PC=0, A=0, D=0, IR=0, retired_o=0 and halt_o=0, with precedence over all other updates.
REQ-034 After the reset edge, imem_req_o SHALL be 1 and dmem_req_o SHALL be 0.
REQ-035 Reset asserted during MEM SHALL drop dmem_req_o at the next edge with no register or PC update; an ack in that cycle SHALL be ignored.

Verification
REQ-036 Test: ack every cycle; @2 then D=A (0x0002, 0xEC10) -> D=2, PC=2, retired_o=2 after 4 cycles.
REQ-037 Test: @5; M=D+1 with D=9 and 3 dmem wait cycles -> dmem_req_o held 4 cycles, addr=5, wr_en=1, data_o=10; PC advances only on the ack edge.
REQ-038 Test: @7; M=M+1 with data_i=0xFFFF -> data_o=0x0000 written; for D;JEQ-style variants, zr drives the jump to PC=7.
REQ-039 Test: D=-1 then @20; D;JLT -> PC=20; the same program with D=1 -> PC=PC+1.
REQ-040 Test: at PC=3, @3 then 0;JMP -> halt_o=1, no further imem_req_o, retired_o frozen; reset_i -> PC=0, halt_o=0.
REQ-041 Test: DW=24, AW=20, A-instruction 0x7FFFFF -> A=0x7FFFFF, dmem_addr_o=0xFFFFF; PC wrap from 0xFFFFF -> 0.
